// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared screen/tile geometry, tile codes and the enemy
//               direction encoding used by the enemy controller.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    localparam int SCR_W   = 1920;
    localparam int SCR_H   = 1080;
    localparam int TILE_SZ = 40;
    localparam int MAP_W   = SCR_W / TILE_SZ;
    localparam int MAP_H   = SCR_H / TILE_SZ;

    localparam logic [3:0] TILE_BG   = 4'd0;
    localparam logic [3:0] TILE_WALL = 4'd1;
    localparam logic [3:0] TILE_COIN = 4'd2;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

endpackage
`default_nettype wire

// File: rtl/enemy_ctrl_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : enemy_ctrl_gen_if
// Description : Tile-lookup req/ack bus between the enemy controller
//               (master) and the map ROM/RAM arbiter (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface enemy_ctrl_gen_if;

    logic        tile_req;
    logic [10:0] tile_addr;
    logic        tile_ack;
    logic [3:0]  tile_code;

    modport master (
        output tile_req,
        output tile_addr,
        input  tile_ack,
        input  tile_code
    );

    modport slave (
        input  tile_req,
        input  tile_addr,
        output tile_ack,
        output tile_code
    );

endinterface
`default_nettype wire

// File: rtl/enemy_probe.sv
`default_nettype none
// ============================================================================
// Module      : enemy_probe
// Description : Leading-edge probe point for one enemy moving one step in a
//               given direction, screen-bound check and pixel-to-tile index.
// Revision    : 1.0 - initial release
// ============================================================================
module enemy_probe
    import game_pkg::*;
#(
    parameter int SCR_W      = game_pkg::SCR_W,
    parameter int SCR_H      = game_pkg::SCR_H,
    parameter int TILE_SZ    = game_pkg::TILE_SZ,
    parameter int ENEMY_SIZE = 40,
    parameter int STEP       = 2
) (
    input  logic [11:0] i_x,
    input  logic [11:0] i_y,
    input  dir_t        i_dir,
    output logic        o_in_bounds,
    output logic [10:0] o_tile_addr
);

    localparam int          c_MAP_W = SCR_W / TILE_SZ;
    localparam logic [11:0] c_STEP  = 12'(STEP);
    localparam logic [11:0] c_HALF  = 12'(ENEMY_SIZE / 2);
    localparam logic [11:0] c_FAR   = 12'(ENEMY_SIZE - 1 + STEP);

    logic [11:0] w_px;
    logic [11:0] w_py;
    logic        w_under;
    logic [10:0] w_row;
    logic [10:0] w_col;

    // Probe point one step ahead; underflow is caught before subtracting.
    always_comb begin
        w_px    = i_x + c_HALF;
        w_py    = i_y;
        w_under = 1'b0;
        case (i_dir)
            UP: begin
                w_under = (i_y < c_STEP);
                w_px    = i_x + c_HALF;
                w_py    = i_y - c_STEP;
            end
            DOWN: begin
                w_px = i_x + c_HALF;
                w_py = i_y + c_FAR;
            end
            LEFT: begin
                w_under = (i_x < c_STEP);
                w_px    = i_x - c_STEP;
                w_py    = i_y + c_HALF;
            end
            default: begin
                w_px = i_x + c_FAR;
                w_py = i_y + c_HALF;
            end
        endcase
        o_in_bounds = !w_under && (w_px < 12'(SCR_W)) && (w_py < 12'(SCR_H));
    end

    // Exact constant divide; quotients are far below 2^11 on any legal screen.
    assign w_row       = 11'(w_py / 12'(TILE_SZ));
    assign w_col       = 11'(w_px / 12'(TILE_SZ));
    assign o_tile_addr = w_row * 11'(c_MAP_W) + w_col;

endmodule
`default_nettype wire

// File: rtl/enemy_ctrl_gen.sv
`default_nettype none
// ============================================================================
// Module      : enemy_ctrl_gen
// Description : Moves NUM_ENEMY enemies around the tile maze. After each
//               frame_tick the enemies are serviced one at a time through a
//               shared tile-lookup port; a step is taken only when the tile
//               ahead is not a wall.
//               Optional macro ENEMY_CHASE_EN: when a new direction is
//               drawn and lfsr[0] is set, head toward the player instead.
// Revision    : 1.0 - initial release
// ============================================================================
module enemy_ctrl_gen
    import game_pkg::*;
#(
    parameter int          NUM_ENEMY  = 4,
    parameter int          SCR_W      = game_pkg::SCR_W,
    parameter int          SCR_H      = game_pkg::SCR_H,
    parameter int          TILE_SZ    = game_pkg::TILE_SZ,
    parameter int          ENEMY_SIZE = 40,
    parameter int          STEP       = 2,
    parameter logic [15:0] LFSR_SEED  = 16'hABCD
) (
    input  logic                      clk_pix,
    input  logic                      rst,
    input  logic                      frame_tick,
    input  logic                      game_reset,
    enemy_ctrl_gen_if.master          tile_bus,
    input  logic [11:0]               pac_x,
    input  logic [11:0]               pac_y,
    output logic [12*NUM_ENEMY-1:0]   enemy_x_flat,
    output logic [12*NUM_ENEMY-1:0]   enemy_y_flat,
    output logic                      busy,
    output logic                      scan_done,
    output logic                      overrun
);

    localparam int                 c_IDX_W = (NUM_ENEMY > 1) ? $clog2(NUM_ENEMY) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(NUM_ENEMY - 1);
    localparam logic [11:0]        c_STEP  = 12'(STEP);
    localparam logic [11:0]        c_X_FAR = 12'(SCR_W - ENEMY_SIZE);
    localparam logic [11:0]        c_Y_FAR = 12'(SCR_H - ENEMY_SIZE);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_PICK   = 3'd1;
    localparam logic [2:0] c_ST_WAIT   = 3'd2;
    localparam logic [2:0] c_ST_COMMIT = 3'd3;
    localparam logic [2:0] c_ST_BLOCK  = 3'd4;
    localparam logic [2:0] c_ST_NEXT   = 3'd5;

    logic [2:0]         r_state;
    logic [c_IDX_W-1:0] r_idx;
    logic [15:0]        r_lfsr;
    logic [11:0]        r_x    [NUM_ENEMY];
    logic [11:0]        r_y    [NUM_ENEMY];
    dir_t               r_dir  [NUM_ENEMY];
    logic [5:0]         r_dist [NUM_ENEMY];
    logic               r_tile_req;
    logic [10:0]        r_tile_addr;
    logic               r_busy;
    logic               r_scan_done;
    logic               r_overrun;

    logic [11:0] w_cur_x;
    logic [11:0] w_cur_y;
    dir_t        w_new_dir;
    dir_t        w_pick_dir;
    logic        w_in_bounds;
    logic [10:0] w_probe_addr;
    logic        w_lfsr_fb;

    function automatic logic [11:0] f_spawn_x(input int i);
        return ((i % 4) == 1 || (i % 4) == 3) ? c_X_FAR : 12'd0;
    endfunction

    function automatic logic [11:0] f_spawn_y(input int i);
        return ((i % 4) >= 2) ? c_Y_FAR : 12'd0;
    endfunction

    assign w_cur_x = r_x[r_idx];
    assign w_cur_y = r_y[r_idx];

`ifdef ENEMY_CHASE_EN
    logic [11:0] w_adx;
    logic [11:0] w_ady;
    dir_t        w_chase_dir;

    // Head toward the player along the axis with the larger gap (ties -> X).
    always_comb begin
        w_adx = (pac_x >= w_cur_x) ? (pac_x - w_cur_x) : (w_cur_x - pac_x);
        w_ady = (pac_y >= w_cur_y) ? (pac_y - w_cur_y) : (w_cur_y - pac_y);
        if (w_adx >= w_ady) begin
            w_chase_dir = (pac_x > w_cur_x) ? RIGHT : LEFT;
        end else begin
            w_chase_dir = (pac_y > w_cur_y) ? DOWN : UP;
        end
    end

    assign w_new_dir = r_lfsr[0] ? w_chase_dir : dir_t'(r_lfsr[15:14]);
`else
    logic w_pac_unused;
    assign w_pac_unused = ^{pac_x, pac_y};
    assign w_new_dir    = dir_t'(r_lfsr[15:14]);
`endif

    // A fresh direction is only drawn once the current run is exhausted.
    assign w_pick_dir = (r_dist[r_idx] == 6'd0) ? w_new_dir : r_dir[r_idx];

    enemy_probe #(
        .SCR_W      (SCR_W),
        .SCR_H      (SCR_H),
        .TILE_SZ    (TILE_SZ),
        .ENEMY_SIZE (ENEMY_SIZE),
        .STEP       (STEP)
    ) u_probe (
        .i_x         (w_cur_x),
        .i_y         (w_cur_y),
        .i_dir       (w_pick_dir),
        .o_in_bounds (w_in_bounds),
        .o_tile_addr (w_probe_addr)
    );

    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // Free-running LFSR; only the hard reset reseeds it.
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    // Scan sequencer: one enemy at a time, PICK -> (WAIT) -> COMMIT/BLOCK -> NEXT.
    always_ff @(posedge clk_pix) begin
        if (rst || game_reset) begin
            r_state     <= c_ST_IDLE;
            r_idx       <= '0;
            r_tile_req  <= 1'b0;
            r_tile_addr <= '0;
            r_busy      <= 1'b0;
            r_scan_done <= 1'b0;
            r_overrun   <= 1'b0;
            for (int i = 0; i < NUM_ENEMY; i++) begin
                r_x[i]    <= f_spawn_x(i);
                r_y[i]    <= f_spawn_y(i);
                r_dir[i]  <= UP;
                r_dist[i] <= 6'd0;
            end
        end else begin
            r_scan_done <= 1'b0;
            r_overrun   <= frame_tick && r_busy;
            case (r_state)
                c_ST_IDLE: begin
                    if (frame_tick) begin
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_ST_PICK;
                    end
                end
                c_ST_PICK: begin
                    r_dir[r_idx] <= w_pick_dir;
                    if (r_dist[r_idx] == 6'd0) begin
                        r_dist[r_idx] <= r_lfsr[13:8];
                    end
                    if (w_in_bounds) begin
                        r_tile_req  <= 1'b1;
                        r_tile_addr <= w_probe_addr;
                        r_state     <= c_ST_WAIT;
                    end else begin
                        r_state <= c_ST_BLOCK;
                    end
                end
                c_ST_WAIT: begin
                    if (tile_bus.tile_ack) begin
                        r_tile_req <= 1'b0;
                        r_state    <= (tile_bus.tile_code == TILE_WALL) ? c_ST_BLOCK : c_ST_COMMIT;
                    end
                end
                c_ST_COMMIT: begin
                    case (r_dir[r_idx])
                        UP:      r_y[r_idx] <= r_y[r_idx] - c_STEP;
                        DOWN:    r_y[r_idx] <= r_y[r_idx] + c_STEP;
                        LEFT:    r_x[r_idx] <= r_x[r_idx] - c_STEP;
                        default: r_x[r_idx] <= r_x[r_idx] + c_STEP;
                    endcase
                    if (r_dist[r_idx] != 6'd0) begin
                        r_dist[r_idx] <= r_dist[r_idx] - 6'd1;
                    end
                    r_state <= c_ST_NEXT;
                end
                c_ST_BLOCK: begin
                    r_dist[r_idx] <= 6'd0;
                    r_state       <= c_ST_NEXT;
                end
                c_ST_NEXT: begin
                    if (r_idx == c_LAST) begin
                        r_scan_done <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= c_ST_IDLE;
                    end else begin
                        r_idx   <= r_idx + c_IDX_W'(1);
                        r_state <= c_ST_PICK;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    generate
        for (genvar g = 0; g < NUM_ENEMY; g++) begin : g_flat
            assign enemy_x_flat[12*g +: 12] = r_x[g];
            assign enemy_y_flat[12*g +: 12] = r_y[g];
        end
    endgenerate

    assign tile_bus.tile_req  = r_tile_req;
    assign tile_bus.tile_addr = r_tile_addr;
    assign busy               = r_busy;
    assign scan_done          = r_scan_done;
    assign overrun            = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_enemy_ctrl_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_enemy_ctrl_gen
// Description : Self-checking bench for enemy_ctrl_gen (8 enemies). A
//               behavioural model tracks every enemy's position, direction
//               and remaining run length in plain integer arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_enemy_ctrl_gen;

    localparam int          N    = 8;
    localparam logic [15:0] SEED = 16'hABCD;

    logic              clk_pix = 1'b0;
    logic              rst;
    logic              frame_tick;
    logic              game_reset;
    logic [11:0]       pac_x;
    logic [11:0]       pac_y;
    logic [12*N-1:0]   enemy_x_flat;
    logic [12*N-1:0]   enemy_y_flat;
    logic              busy;
    logic              scan_done;
    logic              overrun;

    enemy_ctrl_gen_if bus ();

    enemy_ctrl_gen #(.NUM_ENEMY(N)) dut (
        .clk_pix      (clk_pix),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .game_reset   (game_reset),
        .tile_bus     (bus),
        .pac_x        (pac_x),
        .pac_y        (pac_y),
        .enemy_x_flat (enemy_x_flat),
        .enemy_y_flat (enemy_y_flat),
        .busy         (busy),
        .scan_done    (scan_done),
        .overrun      (overrun)
    );

    always #5 clk_pix = ~clk_pix;

    // Reference LFSR: taps 15,13,12,10 as a parity mask, new bit enters at 0.
    logic [15:0] m_lfsr;
    always @(posedge clk_pix) begin
        if (rst) m_lfsr <= SEED;
        else     m_lfsr <= {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
    end

    int total = 0;
    int bad   = 0;
    int mx [N];
    int my [N];
    int mdir [N];
    int mdist [N];

    typedef struct { int ex; int ey; } corner_t;
    corner_t corners [4];

    typedef struct { int delay; int ov; int exp_ov; } scan_vec_t;
    scan_vec_t scans [10];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_pix);
        #1;
    endtask

    function automatic void spawn_model();
        for (int i = 0; i < N; i++) begin
            mx[i] = corners[i % 4].ex;
            my[i] = corners[i % 4].ey;
            mdir[i] = 0;
            mdist[i] = 0;
        end
    endfunction

    task automatic check_positions(input string tag);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s_x%0d", tag, i), int'(enemy_x_flat[12*i +: 12]), mx[i]);
            chk($sformatf("%s_y%0d", tag, i), int'(enemy_y_flat[12*i +: 12]), my[i]);
        end
    endtask

    // 0=UP 1=DOWN 2=LEFT 3=RIGHT
    function automatic int pick_dir(input int k);
        int dx, dy, adx, ady;
        dx = int'(pac_x) - mx[k];
        dy = int'(pac_y) - my[k];
        adx = (dx < 0) ? -dx : dx;
        ady = (dy < 0) ? -dy : dy;
`ifdef ENEMY_CHASE_EN
        if (m_lfsr[0]) begin
            if (adx >= ady) return (dx > 0) ? 3 : 2;
            else            return (dy > 0) ? 1 : 0;
        end
`endif
        if (adx < 0 || ady < 0) return 0;
        return int'(m_lfsr[15:14]);
    endfunction

    function automatic bit probe(input int x, input int y, input int d, output int addr);
        int px, py;
        case (d)
            0:       begin px = x + 20; py = y - 2;  end
            1:       begin px = x + 20; py = y + 41; end
            2:       begin px = x - 2;  py = y + 20; end
            default: begin px = x + 41; py = y + 20; end
        endcase
        addr = 0;
        if (px < 0 || px >= 1920 || py < 0 || py >= 1080) return 1'b0;
        addr = (py / 40) * 48 + (px / 40);
        return 1'b1;
    endfunction

    // One full scan with a fixed ack delay; optionally a second frame_tick mid-scan.
    task automatic run_scan(input int delay, input int ov, input int exp_ov);
        int  addr, code;
        bit  inb;
        pac_x = 12'($urandom_range(0, 1919));
        pac_y = 12'($urandom_range(0, 1079));
        frame_tick = 1'b1;
        step();
        frame_tick = (ov != 0) ? 1'b1 : 1'b0;
        chk("busy_start", busy, 1);
        for (int k = 0; k < N; k++) begin
            if (mdist[k] == 0) begin
                mdir[k]  = pick_dir(k);
                mdist[k] = int'(m_lfsr[13:8]);
            end
            inb = probe(mx[k], my[k], mdir[k], addr);
            step();
            if (k == 0) begin
                chk("overrun_pulse", overrun, exp_ov);
                frame_tick = 1'b0;
            end
            if (!inb) begin
                chk("no_req_oob", bus.tile_req, 0);
                mdist[k] = 0;
            end else begin
                chk("req_high", bus.tile_req, 1);
                chk("tile_addr", int'(bus.tile_addr), addr);
                for (int w = 0; w < delay; w++) begin
                    step();
                    chk("addr_hold", int'(bus.tile_addr), addr);
                end
                code = $urandom_range(0, 2);
                bus.tile_ack  = 1'b1;
                bus.tile_code = 4'(code);
                step();
                bus.tile_ack  = 1'b0;
                bus.tile_code = 4'd0;
                chk("req_drop", bus.tile_req, 0);
                if (code == 1) begin
                    mdist[k] = 0;
                end else begin
                    case (mdir[k])
                        0:       my[k] -= 2;
                        1:       my[k] += 2;
                        2:       mx[k] -= 2;
                        default: mx[k] += 2;
                    endcase
                    if (mdist[k] > 0) mdist[k]--;
                end
            end
            step();
            step();
        end
        chk("scan_done", scan_done, 1);
        chk("busy_end", busy, 0);
        check_positions("scan");
        step();
        chk("scan_done_pulse", scan_done, 0);
        chk("overrun_idle", overrun, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  cnt;
        bit  done;

        corners[0] = '{0, 0};
        corners[1] = '{1880, 0};
        corners[2] = '{0, 1040};
        corners[3] = '{1880, 1040};

        scans[0] = '{0, 0, 0};
        scans[1] = '{3, 0, 0};
        scans[2] = '{0, 1, 1};
        scans[3] = '{1, 0, 0};
        scans[4] = '{2, 1, 1};
        scans[5] = '{0, 0, 0};
        scans[6] = '{4, 0, 0};
        scans[7] = '{0, 0, 0};
        scans[8] = '{1, 1, 1};
        scans[9] = '{0, 0, 0};

        rst = 1'b1; frame_tick = 1'b0; game_reset = 1'b0;
        pac_x = 12'd0; pac_y = 12'd0;
        bus.tile_ack = 1'b0; bus.tile_code = 4'd0;
        step();
        step();
        spawn_model();
        chk("rst_busy", busy, 0);
        chk("rst_req", bus.tile_req, 0);
        chk("rst_done", scan_done, 0);
        chk("rst_overrun", overrun, 0);
        check_positions("reset");
        rst = 1'b0;

        for (int s = 0; s < 10; s++) begin
            run_scan(scans[s].delay, scans[s].ov, scans[s].exp_ov);
        end
        for (int s = 0; s < 20; s++) begin
            run_scan($urandom_range(0, 4), 0, 0);
        end

        // Zero-wait throughput: scan_done must arrive within 4 cycles per enemy.
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        cnt = 0; done = 1'b0;
        while (!done && cnt < 200) begin
            bus.tile_ack  = bus.tile_req;
            bus.tile_code = 4'd0;
            step();
            cnt++;
            if (scan_done) done = 1'b1;
        end
        bus.tile_ack = 1'b0;
        chk("tp_scan_done_seen", int'(done), 1);
        chk("tp_within_32", int'(cnt <= 32), 1);

        // Abort: game_reset while a lookup is outstanding.
        cnt = 0;
        while (!bus.tile_req && cnt < 500) begin
            frame_tick = !busy;
            step();
            cnt++;
        end
        frame_tick = 1'b0;
        chk("abort_req_seen", bus.tile_req, 1);
        game_reset = 1'b1;
        step();
        game_reset = 1'b0;
        chk("abort_req_low", bus.tile_req, 0);
        chk("abort_busy_low", busy, 0);
        bus.tile_ack = 1'b1; bus.tile_code = 4'd0;
        step();
        bus.tile_ack = 1'b0;
        chk("late_ack_req", bus.tile_req, 0);
        step();
        spawn_model();
        check_positions("abort");
        chk("abort_busy_idle", busy, 0);
        chk("abort_no_done", scan_done, 0);

        for (int s = 0; s < 6; s++) begin
            run_scan($urandom_range(0, 2), 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
